// File: rtl/sdr_dec_pkg.sv
// rtl/sdr_dec_pkg.sv - shared types and pin decode for the SDRAM command-bus decoder
//
// Purpose: command and violation enums, bank geometry constants, and the
//          {cs_n,ras_n,cas_n,we_n} pin decode used by sdr_cmd_decoder.
// Ports:   none (package).
// Config:  SDR_DEC_TIMING_CHECK_EN is consumed by the modules, not here.

package sdr_dec_pkg;

  localparam int NUM_BANKS = 4;
  localparam int ROW_W     = 13;

  typedef enum logic [3:0] {
    CMD_NOP   = 4'd0,
    CMD_ACT   = 4'd1,
    CMD_READ  = 4'd2,
    CMD_WRITE = 4'd3,
    CMD_PRE   = 4'd4,
    CMD_REF   = 4'd5,
    CMD_MRS   = 4'd6,
    CMD_BST   = 4'd7,
    CMD_DESEL = 4'd8
  } sdr_cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_ACT_OPEN = 3'd1,
    ERR_CLOSED   = 3'd2,
    ERR_RCD      = 3'd3,
    ERR_RP       = 3'd4,
    ERR_REF_OPEN = 3'd5,
    ERR_MRD      = 3'd6
  } sdr_err_e;

  // pins = {cs_n, ras_n, cas_n, we_n}
  function automatic sdr_cmd_e sdr_decode(input logic [3:0] pins);
    sdr_cmd_e c;
    c = CMD_NOP;
    casez (pins)
      4'b1???: c = CMD_DESEL;
      4'b0111: c = CMD_NOP;
      4'b0011: c = CMD_ACT;
      4'b0101: c = CMD_READ;
      4'b0100: c = CMD_WRITE;
      4'b0010: c = CMD_PRE;
      4'b0001: c = CMD_REF;
      4'b0000: c = CMD_MRS;
      4'b0110: c = CMD_BST;
      default: c = CMD_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sdr_bank_tracker.sv
// rtl/sdr_bank_tracker.sv - open/row state and tRCD/tRP counters for one SDRAM bank
//
// Purpose: tracks one bank from the decoded command stream and reports the
//          per-bank violation conditions; the top resolves priority.
// Ports:   clk, rst          clock, synchronous active-high reset
//          cmd[3:0]          decoded command (sdr_cmd_e), NOP when idle
//          hit               command addresses this bank (incl. precharge-all)
//          auto_pre          addr[10] of the command
//          row[ROW_W-1:0]    row address captured on ACT
//          is_open, open_row bank state
//          err_act_open, err_closed, err_rcd, err_rp   violation conditions
// Config:  SDR_DEC_TIMING_CHECK_EN adds the rcd/rp counters; otherwise
//          err_rcd/err_rp are tied low.

module sdr_bank_tracker
  import sdr_dec_pkg::*;
`ifdef SDR_DEC_TIMING_CHECK_EN
#(
  parameter int T_RCD = 3,
  parameter int T_RP  = 3
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       cmd,
  input  logic             hit,
  input  logic             auto_pre,
  input  logic [ROW_W-1:0] row,
  output logic             is_open,
  output logic [ROW_W-1:0] open_row,
  output logic             err_act_open,
  output logic             err_closed,
  output logic             err_rcd,
  output logic             err_rp
);

  logic open_q;
  logic [ROW_W-1:0] row_q;
  logic is_act;
  logic is_rdwr;
  logic close_now;

  assign is_act    = hit && (cmd == CMD_ACT);
  assign is_rdwr   = hit && ((cmd == CMD_READ) || (cmd == CMD_WRITE));
  // Explicit precharge, or the implicit one that follows an auto-precharge access.
  assign close_now = hit && ((cmd == CMD_PRE) || (is_rdwr && auto_pre));

  // Illegal commands still update state so later checks follow the real device.
  always_ff @(posedge clk) begin
    if (rst) begin
      open_q <= 1'b0;
      row_q  <= '0;
    end else if (is_act) begin
      open_q <= 1'b1;
      row_q  <= row;
    end else if (close_now) begin
      open_q <= 1'b0;
    end
  end

  assign is_open      = open_q;
  assign open_row     = row_q;
  assign err_act_open = is_act && open_q;
  assign err_closed   = is_rdwr && !open_q;

`ifdef SDR_DEC_TIMING_CHECK_EN
  localparam int RCD_W = (T_RCD > 1) ? $clog2(T_RCD) : 1;
  localparam int RP_W  = (T_RP  > 1) ? $clog2(T_RP)  : 1;

  logic [RCD_W-1:0] rcd_q;
  logic [RP_W-1:0]  rp_q;

  // Loading T-1 at the command edge makes the counter read zero exactly T edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rcd_q <= '0;
      rp_q  <= '0;
    end else begin
      if (is_act)
        rcd_q <= RCD_W'(T_RCD - 1);
      else if (rcd_q != '0)
        rcd_q <= rcd_q - RCD_W'(1);

      if (close_now)
        rp_q <= RP_W'(T_RP - 1);
      else if (rp_q != '0)
        rp_q <= rp_q - RP_W'(1);
    end
  end

  assign err_rcd = is_rdwr && (rcd_q != '0);
  // REF needs every bank precharged, so it checks rp regardless of the bank select.
  assign err_rp  = (is_act || (cmd == CMD_REF)) && (rp_q != '0);
`else
  assign err_rcd = 1'b0;
  assign err_rp  = 1'b0;
`endif

endmodule

// File: rtl/sdr_cmd_decoder.sv
// rtl/sdr_cmd_decoder.sv - passive SDRAM command-bus decoder and protocol checker
//
// Purpose: captures the SDRAM command pins, decodes one command per cycle,
//          tracks per-bank state and flags protocol/timing violations.
//          Drives no DUV signal.
// Ports:   sdram_clk, sdram_rst          clock, synchronous active-high reset
//          sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr
//                                        command pins
//          cmd_valid, cmd_code, cmd_bank, cmd_addr   decoded command
//          bank_open                     per-bank open flags
//          err_valid, err_code, err_cnt  violation report and saturating count
// Config:  SDR_DEC_TIMING_CHECK_EN enables the tRCD/tRP/tMRD checks (codes 3, 4, 6).

module sdr_cmd_decoder
  import sdr_dec_pkg::*;
#(
  parameter int T_RCD = 3,
  parameter int T_RP  = 3,
  parameter int T_MRD = 2
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst,
  input  logic        sdr_cke,
  input  logic        sdr_cs_n,
  input  logic        sdr_ras_n,
  input  logic        sdr_cas_n,
  input  logic        sdr_we_n,
  input  logic [1:0]  sdr_ba,
  input  logic [12:0] sdr_addr,
  output logic        cmd_valid,
  output logic [3:0]  cmd_code,
  output logic [1:0]  cmd_bank,
  output logic [12:0] cmd_addr,
  output logic [3:0]  bank_open,
  output logic        err_valid,
  output logic [2:0]  err_code,
  output logic [15:0] err_cnt
);

  // Every timing parameter must be at least one cycle.
  if (T_RCD < 1 || T_RP < 1 || T_MRD < 1) begin : g_illegal_timing_param
  end

  // Pin capture stage; reset parks it on DESEL so nothing sampled in reset is seen.
  logic        cap_cke;
  logic [3:0]  cap_pins;
  logic [1:0]  cap_ba;
  logic [12:0] cap_addr;

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      cap_cke  <= 1'b0;
      cap_pins <= 4'b1111;
      cap_ba   <= '0;
      cap_addr <= '0;
    end else begin
      cap_cke  <= sdr_cke;
      cap_pins <= {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};
      cap_ba   <= sdr_ba;
      cap_addr <= sdr_addr;
    end
  end

  sdr_cmd_e cmd_dec;
  logic     dec_valid;

  always_comb begin
    cmd_dec   = CMD_NOP;
    dec_valid = 1'b0;
    if (cap_cke)
      cmd_dec = sdr_decode(cap_pins);
    dec_valid = (cmd_dec != CMD_NOP) && (cmd_dec != CMD_DESEL);
  end

  logic [NUM_BANKS-1:0] bank_hit;
  logic [NUM_BANKS-1:0] open_v;
  logic [NUM_BANKS-1:0] e_act_open;
  logic [NUM_BANKS-1:0] e_closed;
  logic [NUM_BANKS-1:0] e_rcd;
  logic [NUM_BANKS-1:0] e_rp;
  // Stored rows are kept for hierarchical whitebox probes; no output needs them.
  logic [ROW_W-1:0]     unused_open_row [NUM_BANKS];

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    assign bank_hit[i] = (cap_ba == 2'(i)) || ((cmd_dec == CMD_PRE) && cap_addr[10]);

    sdr_bank_tracker
`ifdef SDR_DEC_TIMING_CHECK_EN
    #(
      .T_RCD (T_RCD),
      .T_RP  (T_RP)
    )
`endif
    u_bank (
      .clk          (sdram_clk),
      .rst          (sdram_rst),
      .cmd          (cmd_dec),
      .hit          (bank_hit[i]),
      .auto_pre     (cap_addr[10]),
      .row          (cap_addr),
      .is_open      (open_v[i]),
      .open_row     (unused_open_row[i]),
      .err_act_open (e_act_open[i]),
      .err_closed   (e_closed[i]),
      .err_rcd      (e_rcd[i]),
      .err_rp       (e_rp[i])
    );
  end

  assign bank_open = open_v;

  logic mrd_busy;

`ifdef SDR_DEC_TIMING_CHECK_EN
  localparam int MRD_W = (T_MRD > 1) ? $clog2(T_MRD) : 1;
  logic [MRD_W-1:0] mrd_q;

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst)
      mrd_q <= '0;
    else if (cmd_dec == CMD_MRS)
      mrd_q <= MRD_W'(T_MRD - 1);
    else if (mrd_q != '0)
      mrd_q <= mrd_q - MRD_W'(1);
  end

  assign mrd_busy = (mrd_q != '0);
`else
  assign mrd_busy = 1'b0;
`endif

  sdr_err_e err_now;

  // Lowest code wins when several violations coincide.
  always_comb begin
    err_now = ERR_NONE;
    if (|e_act_open)
      err_now = ERR_ACT_OPEN;
    else if (|e_closed)
      err_now = ERR_CLOSED;
    else if (|e_rcd)
      err_now = ERR_RCD;
    else if (|e_rp)
      err_now = ERR_RP;
    else if (((cmd_dec == CMD_REF) || (cmd_dec == CMD_MRS)) && (|open_v))
      err_now = ERR_REF_OPEN;
    else if (dec_valid && mrd_busy)
      err_now = ERR_MRD;
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_bank  <= '0;
      cmd_addr  <= '0;
      err_valid <= 1'b0;
      err_code  <= '0;
      err_cnt   <= '0;
    end else begin
      cmd_valid <= dec_valid;
      cmd_code  <= dec_valid ? cmd_dec : CMD_NOP;
      cmd_bank  <= cap_ba;
      cmd_addr  <= cap_addr;
      err_valid <= (err_now != ERR_NONE);
      err_code  <= err_now;
      if ((err_now != ERR_NONE) && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sdr_cmd_decoder.sv
// tb/tb_sdr_cmd_decoder.sv - scoreboard testbench for sdr_cmd_decoder

module tb_sdr_cmd_decoder;
  import sdr_dec_pkg::*;

`ifdef SDR_DEC_TIMING_CHECK_EN
  localparam bit TC = 1'b1;
`else
  localparam bit TC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cke;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic        cmd_valid;
  logic [3:0]  cmd_code;
  logic [1:0]  cmd_bank;
  logic [12:0] cmd_addr;
  logic [3:0]  bank_open;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [15:0] err_cnt;

  sdr_cmd_decoder dut (
    .sdram_clk (clk),
    .sdram_rst (rst),
    .sdr_cke   (cke),
    .sdr_cs_n  (cs_n),
    .sdr_ras_n (ras_n),
    .sdr_cas_n (cas_n),
    .sdr_we_n  (we_n),
    .sdr_ba    (ba),
    .sdr_addr  (addr),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_bank  (cmd_bank),
    .cmd_addr  (cmd_addr),
    .bank_open (bank_open),
    .err_valid (err_valid),
    .err_code  (err_code),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [1:0]  bank;
    logic [12:0] addr;
    logic [2:0]  err;
    logic [3:0]  open;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_x;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] pins_of(input sdr_cmd_e c);
    case (c)
      CMD_ACT:   return 4'b0011;
      CMD_READ:  return 4'b0101;
      CMD_WRITE: return 4'b0100;
      CMD_PRE:   return 4'b0010;
      CMD_REF:   return 4'b0001;
      CMD_MRS:   return 4'b0000;
      CMD_BST:   return 4'b0110;
      default:   return 4'b0111;
    endcase
  endfunction

  task automatic drive(input logic [3:0] pins, input logic [1:0] b, input logic [12:0] a);
    {cs_n, ras_n, cas_n, we_n} = pins;
    ba   = b;
    addr = a;
  endtask

  task automatic issue(input sdr_cmd_e c, input logic [1:0] b, input logic [12:0] a,
                       input logic [2:0] e, input logic [3:0] open);
    exp_t x;
    @(negedge clk);
    drive(pins_of(c), b, a);
    if (e != 3'd0) exp_cnt++;
    x.code = c;
    x.bank = b;
    x.addr = a;
    x.err  = e;
    x.open = open;
    x.cnt  = 16'(exp_cnt);
    q.push_back(x);
  endtask

  task automatic nop(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(4'b0111, 2'd0, 13'd0);
    end
  endtask

  // Monitor: every presented command is matched against the oldest expectation.
  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd: got code 0x%0h bank %0d expected no command", cmd_code, cmd_bank);
      end else begin
        mon_x = q.pop_front();
        check("cmd_code",  32'(cmd_code),  32'(mon_x.code));
        check("cmd_bank",  32'(cmd_bank),  32'(mon_x.bank));
        check("cmd_addr",  32'(cmd_addr),  32'(mon_x.addr));
        check("err_valid", 32'(err_valid), 32'(mon_x.err != 3'd0));
        check("err_code",  32'(err_code),  32'(mon_x.err));
        check("bank_open", 32'(bank_open), 32'(mon_x.open));
        check("err_cnt",   32'(err_cnt),   32'(mon_x.cnt));
      end
    end else if (err_valid === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL err_without_cmd: got err_code %0d expected no error", err_code);
    end
  end

  task automatic check_idle_zero(input string tag);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_cmd_code"},  32'(cmd_code),  32'd0);
    check({tag, "_cmd_bank"},  32'(cmd_bank),  32'd0);
    check({tag, "_cmd_addr"},  32'(cmd_addr),  32'd0);
    check({tag, "_bank_open"}, 32'(bank_open), 32'd0);
    check({tag, "_err_valid"}, 32'(err_valid), 32'd0);
    check({tag, "_err_code"},  32'(err_code),  32'd0);
    check({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cke = 1'b1;
    drive(4'b0111, 2'd0, 13'd0);
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    nop(2);

    // tRCD met at n+3, then violated at n+2
    issue(CMD_ACT,   2'd0, 13'h123, 3'd0, 4'b0001);
    nop(2);
    issue(CMD_READ,  2'd0, 13'h010, 3'd0, 4'b0001);
    issue(CMD_PRE,   2'd0, 13'h000, 3'd0, 4'b0000);
    nop(2);
    issue(CMD_ACT,   2'd0, 13'h055, 3'd0, 4'b0001);
    nop(1);
    issue(CMD_READ,  2'd0, 13'h020, TC ? 3'd3 : 3'd0, 4'b0001);

    // ACT to an already-open bank
    issue(CMD_ACT,   2'd1, 13'h0AA, 3'd0, 4'b0011);
    nop(4);
    issue(CMD_ACT,   2'd1, 13'h0BB, 3'd1, 4'b0011);

    // open all banks, precharge-all, tRP at n+2 then clean at n+3
    issue(CMD_ACT,   2'd2, 13'h0CC, 3'd0, 4'b0111);
    issue(CMD_ACT,   2'd3, 13'h0DD, 3'd0, 4'b1111);
    issue(CMD_BST,   2'd0, 13'h000, 3'd0, 4'b1111);
    issue(CMD_PRE,   2'd0, 13'h400, 3'd0, 4'b0000);
    nop(1);
    issue(CMD_ACT,   2'd2, 13'h0EE, TC ? 3'd4 : 3'd0, 4'b0100);
    issue(CMD_ACT,   2'd1, 13'h011, 3'd0, 4'b0110);
    issue(CMD_PRE,   2'd0, 13'h400, 3'd0, 4'b0000);
    nop(2);
    issue(CMD_ACT,   2'd2, 13'h0EF, 3'd0, 4'b0100);

    // REF with a bank open
    issue(CMD_ACT,   2'd3, 13'h0F0, 3'd0, 4'b1100);
    issue(CMD_REF,   2'd0, 13'h000, 3'd5, 4'b1100);

    // tMRD violated one cycle after MRS, then met at two
    issue(CMD_PRE,   2'd0, 13'h400, 3'd0, 4'b0000);
    nop(2);
    issue(CMD_MRS,   2'd0, 13'h033, 3'd0, 4'b0000);
    issue(CMD_ACT,   2'd0, 13'h044, TC ? 3'd6 : 3'd0, 4'b0001);
    nop(2);
    issue(CMD_PRE,   2'd0, 13'h000, 3'd0, 4'b0000);
    nop(2);
    issue(CMD_MRS,   2'd0, 13'h033, 3'd0, 4'b0000);
    nop(1);
    issue(CMD_ACT,   2'd0, 13'h045, 3'd0, 4'b0001);

    // auto-precharge write closes the bank; next READ hits a closed bank
    nop(2);
    issue(CMD_WRITE, 2'd0, 13'h400, 3'd0, 4'b0000);
    issue(CMD_READ,  2'd0, 13'h008, 3'd2, 4'b0000);

    // cke low: the ACT must be ignored
    @(negedge clk);
    cke = 1'b0;
    drive(pins_of(CMD_ACT), 2'd2, 13'h066);
    @(negedge clk);
    cke = 1'b1;
    drive(4'b0111, 2'd0, 13'd0);
    issue(CMD_ACT,   2'd1, 13'h099, 3'd0, 4'b0010);
    nop(2);

    // one-cycle reset with an ACT on the pins, then READ to the formerly open bank
    @(negedge clk);
    rst = 1'b1;
    drive(pins_of(CMD_ACT), 2'd2, 13'h077);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0111, 2'd0, 13'd0);
    exp_cnt = 0;
    @(negedge clk);
    check_idle_zero("post_reset");
    issue(CMD_READ,  2'd1, 13'h004, 3'd2, 4'b0000);
    nop(4);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdr_cmd_decoder.md
# sdr_cmd_decoder

Passive SDRAM command-bus decoder, the receiving end of the controller's command pins. Samples `sdr_cs_n/ras_n/cas_n/we_n/ba/addr` at the DUV boundary, decodes each cycle into a command, and tracks per-bank open/closed state and row. It flags protocol and timing violations (tRCD, tRP, tMRD). It sits in the testbench whitebox layer beside the command-pin interface and drives no DUV signal.

## Interface
- `T_RCD`, 3, min cycles ACT→READ/WRITE same bank (≥1)
- `T_RP`, 3, min cycles PRE→ACT/REF same bank (≥1)
- `T_MRD`, 2, min cycles MRS→any non-NOP command (≥1)
- `sdram_clk  in  1  clock; all sampling on rising edge`
- `sdram_rst  in  1  synchronous, active-high reset`
- `sdr_cke  in  1  clock enable; low = command ignored`
- `sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n  in  1 each  command pins`
- `sdr_ba  in  2  bank address`
- `sdr_addr  in  13  row/column address; bit 10 = auto-precharge / precharge-all`
- `cmd_valid  out  1  decoded non-NOP command this cycle`
- `cmd_code  out  4  decoded command (package enum)`
- `cmd_bank  out  2  registered sdr_ba`
- `cmd_addr  out  13  registered sdr_addr`
- `bank_open  out  4  per-bank open flag`
- `err_valid  out  1  violation detected this cycle`
- `err_code  out  3  violation code`
- `err_cnt  out  16  saturating violation count`

## Operation
- Decode {cs_n,ras_n,cas_n,we_n}: 1xxx DESEL, 0111 NOP, 0011 ACT, 0101 READ, 0100 WRITE, 0010 PRE, 0001 REF, 0000 MRS, 0110 BST. DESEL/NOP → cmd_valid=0.
- `sdr_cke`=0: decoded as NOP; counters still run.
- ACT: bank opened, row stored, that bank's rcd counter loaded with T_RCD-1.
- PRE: addr[10]=1 closes all banks and loads all rp counters with T_RP-1; else closes only `sdr_ba`. PRE to a closed bank is legal and still reloads rp.
- READ/WRITE with addr[10]=1 (auto-precharge): closes bank after access and loads rp.
- MRS: loads mrd counter with T_MRD-1.
- Counters decrement by 1 per cycle, saturate at 0.
- Error codes, one per cycle, lowest applicable code wins:
  - 1: ACT to open bank
  - 2: READ/WRITE to closed bank
  - 3: tRCD violation (rcd≠0)
  - 4: tRP violation (ACT or REF while rp≠0)
  - 5: REF/MRS with any bank open
  - 6: tMRD violation (non-NOP while mrd≠0)
- An erroneous command still updates bank state as if legal (ACT to open bank overwrites the row).
- `err_cnt` increments on each err_valid and saturates at 16'hFFFF.

## Timing
- Single-cycle pipeline: pins sampled at edge n; cmd_*, err_*, and bank_open updated at edge n+1.
- Timing rule: command at edge n permits the dependent command at edge n+T.
- Reset: all outputs 0, bank_open=4'b0000, all counters 0, stored rows 0. Reset mid-sequence discards all state, with no error reported for the cycle in reset.
- Reset dominates: commands sampled while sdram_rst=1 are ignored.

## Configuration
- `SDR_DEC_TIMING_CHECK_EN` defined: rcd/rp/mrd counters present, codes 3, 4, 6 reported.
- Undefined: counters removed; only codes 1, 2, 5 reported. Decode and bank tracking are unchanged.

## Structure
- `sdr_dec_pkg`: `sdr_cmd_e` (4-bit command enum), `sdr_err_e` (3-bit error enum), `NUM_BANKS=4`, `ROW_W=13`.
- Sub-module `sdr_bank_tracker`, instantiated ×4. It holds one bank's open flag, row, and rcd/rp counters. Its inputs are the decoded command plus a bank-select hit, and it outputs per-bank error conditions. The top level does the decode, error priority, mrd counter, and err_cnt.

## Test plan
- ACT bank0 row 0x123 at n, READ bank0 at n+3 (T_RCD=3) → bank_open=4'b0001, no error; READ at n+2 instead → err_code 3.
- ACT bank1 twice, 5 cycles apart → second gives err_code 1, err_cnt=1.
- ACT banks 0–3, PRE addr[10]=1 at n, ACT bank2 at n+2 → err_code 4; ACT at n+3 → clean, bank_open=4'b0100.
- REF with bank3 open → err_code 5; MRS then ACT one cycle later (T_MRD=2) → err_code 6.
- WRITE with addr[10]=1 to open bank0 → bank_open[0]=0; READ bank0 next → err_code 2.
- Open bank1, assert sdram_rst one cycle, then READ bank1 → bank_open=0 after reset, err_code 2.
